// File: rtl/ps_frame_writer.sv
// Frame buffer writer: turns the filtered pixel stream into raster BRAM writes
// into a double-banked buffer, flipping banks on each completed frame.
module ps_frame_writer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int DATA_W   = 12,
    parameter int ADDR_W   = 20
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_flush,
    input  logic              i_arm,
    input  logic              i_continuous,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_rd_bank,
    output logic              o_busy,
    output logic              o_line_done,
    output logic              o_frame_done,
    output logic [7:0]        o_frame_count
);

    localparam int X_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int Y_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(H_ACTIVE * V_ACTIVE);

    typedef enum logic {IDLE, CAPTURE} state_t;

    state_t            state, state_next;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [ADDR_W-1:0] addr;
    logic              wr_bank;
    logic              accept;
    logic              line_end;
    logic              frame_end;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        line_end   = (x == X_W'(H_ACTIVE - 1));
        frame_end  = line_end && (y == Y_W'(V_ACTIVE - 1));
        if (i_flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (i_arm) state_next = CAPTURE;
                CAPTURE: begin
                    if (i_valid) begin
                        accept = 1'b1;
                        if (frame_end && !i_continuous) state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state         <= IDLE;
            x             <= '0;
            y             <= '0;
            addr          <= BANK1_BASE;
            wr_bank       <= 1'b1;
            o_wr_en       <= 1'b0;
            o_wr_addr     <= '0;
            o_wr_data     <= '0;
            o_rd_bank     <= 1'b0;
            o_busy        <= 1'b0;
            o_line_done   <= 1'b0;
            o_frame_done  <= 1'b0;
            o_frame_count <= '0;
        end else begin
            state        <= state_next;
            o_busy       <= (state_next == CAPTURE);
            o_wr_en      <= accept;
            o_line_done  <= accept && line_end;
            o_frame_done <= accept && frame_end;
            if (accept) begin
                o_wr_addr <= addr;
                o_wr_data <= i_data;
            end
            // Flush drops the partial frame: rewind to this bank's base, keep the bank.
            if (i_flush) begin
                x    <= '0;
                y    <= '0;
                addr <= wr_bank ? BANK1_BASE : '0;
            end else if (accept) begin
                if (line_end) begin
                    x <= '0;
                    y <= frame_end ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
                if (frame_end) begin
                    wr_bank       <= ~wr_bank;
                    o_rd_bank     <= wr_bank;
                    o_frame_count <= o_frame_count + 8'd1;
                    addr          <= wr_bank ? '0 : BANK1_BASE;
                end else begin
                    addr <= addr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps_frame_writer.sv
// Scoreboard bench for ps_frame_writer on a 4x2 frame (bank base 8).
module tb_ps_frame_writer;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int DW = 12;
    localparam int AW = 5;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          ld;
        logic          fd;
    } wr_t;

    logic          clk = 1'b0;
    logic          rstn, flush, arm, cont, valid;
    logic [DW-1:0] data;
    logic          wr_en, rd_bank, busy, line_done, frame_done;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [7:0]    frame_count;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    wr_t  exp_q[$];
    logic m_cap, m_bank, m_rd_bank;
    int   m_x, m_y;
    logic [7:0] m_count;

    ps_frame_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .DATA_W(DW), .ADDR_W(AW)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .i_arm(arm),
        .i_continuous(cont), .i_data(data), .i_valid(valid),
        .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .o_rd_bank(rd_bank), .o_busy(busy), .o_line_done(line_done),
        .o_frame_done(frame_done), .o_frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cap = 1'b0; m_bank = 1'b1; m_rd_bank = 1'b0;
        m_x = 0; m_y = 0; m_count = 8'd0;
        exp_q.delete();
    endtask

    // Check outputs produced by the previous edge, then drive one cycle of stimulus.
    task automatic step(input logic s_rstn, input logic s_arm, input logic s_valid,
                        input logic [DW-1:0] s_data, input logic s_flush);
        wr_t e;
        @(negedge clk);
        check("wr_en", wr_en, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("wr_addr", wr_addr, e.addr);
            check("wr_data", wr_data, e.data);
            check("line_done", line_done, e.ld);
            check("frame_done", frame_done, e.fd);
        end else begin
            check("line_done_idle", line_done, 0);
            check("frame_done_idle", frame_done, 0);
        end
        check("busy", busy, m_cap);
        check("rd_bank", rd_bank, m_rd_bank);
        check("frame_count", frame_count, m_count);

        rstn = s_rstn; arm = s_arm; valid = s_valid; data = s_data; flush = s_flush;
        if (!s_rstn) begin
            model_reset();
        end else if (s_flush) begin
            m_cap = 1'b0; m_x = 0; m_y = 0;
        end else if (m_cap && s_valid) begin
            e.addr = AW'(int'(m_bank) * H * V + m_y * H + m_x);
            e.data = s_data;
            e.ld   = (m_x == H - 1);
            e.fd   = (m_x == H - 1) && (m_y == V - 1);
            exp_q.push_back(e);
            if (e.fd) begin
                m_rd_bank = m_bank;
                m_bank    = ~m_bank;
                m_count   = m_count + 8'd1;
                m_cap     = cont;
                m_x = 0; m_y = 0;
            end else if (e.ld) begin
                m_x = 0; m_y = m_y + 1;
            end else begin
                m_x = m_x + 1;
            end
        end else if (!m_cap && s_arm) begin
            m_cap = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic pixels(input int n, input int first, input int max_gap);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b1, DW'(first + i), 1'b0);
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        idle(1);
    endtask

    initial begin
        rstn = 1'b0; arm = 1'b0; valid = 1'b0; data = '0; flush = 1'b0; cont = 1'b0;
        model_reset();
        do_reset();
        check("reset_addr", wr_addr, 0);
        check("reset_data", wr_data, 0);

        // valid while IDLE is ignored, then one single frame
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 12'h0FF, 1'b0);
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        pixels(8, 1, 0);
        idle(3);
        check("single_count", frame_count, 1);
        check("single_rd_bank", rd_bank, 1);
        check("single_busy", busy, 0);

        // continuous: two frames, banks 1 then 0
        do_reset();
        cont = 1'b1;
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        pixels(16, 16, 0);
        idle(2);
        check("cont_count", frame_count, 2);
        check("cont_rd_bank", rd_bank, 0);
        check("cont_busy", busy, 1);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1);
        cont = 1'b0;
        idle(2);

        // random gaps between pixels
        do_reset();
        cont = 1'b1;
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        pixels(16, 'h100, 5);
        idle(1);
        check("gap_count", frame_count, 2);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1);
        cont = 1'b0;
        idle(2);

        // flush mid-frame with a valid pixel in the same cycle
        do_reset();
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        pixels(5, 'h200, 0);
        step(1'b1, 1'b0, 1'b1, 12'hABC, 1'b1);
        idle(2);
        check("flush_busy", busy, 0);
        check("flush_count", frame_count, 0);
        check("flush_rd_bank", rd_bank, 0);
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        pixels(8, 'h300, 0);
        idle(2);
        check("flush_refill_count", frame_count, 1);

        // reset mid-frame
        do_reset();
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        pixels(3, 'h400, 0);
        step(1'b0, 1'b0, 1'b1, 12'h777, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        check("rst_mid_addr", wr_addr, 0);
        check("rst_mid_data", wr_data, 0);
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 12'h500, 1'b0);
        @(negedge clk);
        check("rst_first_en", wr_en, 1);
        check("rst_first_addr", wr_addr, 8);
        void'(exp_q.pop_front());

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ps_frame_writer.md
Name: ps_frame_writer

Overview:
- Sink stage directly downstream of the Gaussian/passthrough filter stage.
- Consumes the filtered 12-bit pixel stream (data + valid, no backpressure) and writes each pixel into a double-banked frame buffer BRAM.
- Generates raster write addresses and line/frame completion pulses, and toggles the bank so the display reader always scans the last complete frame.

Parameters:
- H_ACTIVE, 640, pixels per line
- V_ACTIVE, 480, lines per frame
- DATA_W, 12, pixel width (RGB444, or greyscale in [11:4])
- ADDR_W, 20, write address width; must satisfy 2^ADDR_W >= 2*H_ACTIVE*V_ACTIVE

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset, synchronous, active-low
- i_flush  in  1  synchronous abort; clears position counters
- i_arm  in  1  request capture of the next frame (level or pulse)
- i_continuous  in  1  1 = re-arm automatically after each frame
- i_data  in  DATA_W  pixel from filter stage
- i_valid  in  1  pixel valid; no ready, every valid pixel must be accepted
- o_wr_en  out  1  BRAM write strobe
- o_wr_addr  out  ADDR_W  BRAM write address
- o_wr_data  out  DATA_W  BRAM write data
- o_rd_bank  out  1  bank holding the last complete frame, for the display reader
- o_busy  out  1  high in CAPTURE
- o_line_done  out  1  1-cycle pulse on the last pixel of each line
- o_frame_done  out  1  1-cycle pulse on the last pixel of each frame
- o_frame_count  out  8  completed frames, wraps 255->0

Behaviour:
- All outputs are registered.
- Reset values: o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_rd_bank=0, o_busy=0, o_line_done=0, o_frame_done=0, o_frame_count=0. Internal state: wr_bank=1, x=0, y=0, FSM=IDLE.
- FSM states:
  - IDLE: i_valid is ignored (no write). i_arm=1 -> CAPTURE.
  - CAPTURE: o_busy=1. Each i_valid=1 cycle produces a write on the next cycle: o_wr_en=1, o_wr_data=i_data, o_wr_addr = wr_bank*H_ACTIVE*V_ACTIVE + y*H_ACTIVE + x. Latency is exactly 1 cycle.
- Address generation: use a running address register, no multiplier. It increments by 1 per accepted pixel. On bank switch it reloads to the new bank base (0 or H_ACTIVE*V_ACTIVE).
- Counters:
  - x increments per pixel; at x==H_ACTIVE-1, x wraps to 0 and y increments, and o_line_done pulses aligned with that pixel's o_wr_en.
  - At x==H_ACTIVE-1 and y==V_ACTIVE-1:
    - o_frame_done pulses with the write.
    - o_rd_bank <= wr_bank, and wr_bank toggles.
    - o_frame_count increments.
    - x and y clear to 0.
    - Next state is CAPTURE if i_continuous=1, else IDLE.
- i_valid low mid-line: counters hold. Gaps of any length are allowed.
- i_arm while in CAPTURE: ignored.
- Arming mid-stream: capture starts at the first valid pixel after arming. The upstream must flush or start on a frame boundary; the block does not resynchronise.
- i_flush=1 (in any state):
  - Next cycle: x=0, y=0, address reloaded to the current wr_bank base, FSM=IDLE, o_wr_en=0.
  - o_rd_bank, wr_bank and o_frame_count are unchanged; the partial frame is discarded because the bank is not toggled.
  - Flush has priority over i_valid in the same cycle.
- Reset mid-frame: all state returns to reset values on the next edge.
- o_rd_bank changes only on the frame-done cycle, so the reader never sees a partially written bank.

Test Plan:
- H_ACTIVE=4, V_ACTIVE=2 (bank base 8). Reset, i_arm pulse, 8 consecutive valid pixels 0x001..0x008 -> o_wr_addr 8..15 with o_wr_en 1 cycle after each valid; o_line_done on addr 11 and 15; o_frame_done on addr 15; o_rd_bank 0->1; o_frame_count=1; o_busy falls (i_continuous=0).
- Same config, i_continuous=1, 16 pixels -> first frame addr 8..15, second frame addr 0..7; o_rd_bank ends 0; o_frame_count=2; o_busy stays 1.
- Valid pixels with random 0-5 cycle gaps -> address sequence identical to the gapless case; no write on non-valid cycles.
- i_valid=1 while IDLE (no arm) -> o_wr_en stays 0, counters stay 0.
- Arm, 5 pixels, then i_flush (with i_valid=1 in the same cycle) -> no write for the flush-cycle pixel; FSM=IDLE; o_rd_bank and o_frame_count unchanged; re-arm then 8 pixels -> addresses restart at 8.
- Assert i_rstn=0 after 3 pixels of a frame -> all outputs at reset values on the next cycle; after re-arm, the first write goes to addr 8.
